instr_fetch_queue: RTL and testbench

Instruction fetch front-end that sits directly upstream of the single-cycle core's instruction input.
- Issues sequential word fetches to instruction memory over a request/response interface.
- Buffers returned words in a DEPTH-entry FIFO and presents them to the core with a valid/ready handshake.
- On a core-requested redirect (taken BEQ or JUMP), flushes the queue and discards stale in-flight responses.

---
 rtl/instr_fetch_queue.sv | 160 ++++++++++++++++
 tb/tb_instr_fetch_queue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front-end: sequential word fetch, DEPTH-entry queue, redirect flush/drain.
// Define FETCH_STATS_EN to add saturating stat_fetched / stat_flushed counters.
module instr_fetch_queue #(
  parameter int unsigned DEPTH           = 4,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushed
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_next;

  logic [31:0]   fetch_pc, resp_pc, last_instr, last_pc, redir_pc;
  logic [CW-1:0] count, outstanding, stale, out_next, stale_next;
  logic [CW:0]   credit_sum;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   q_data [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic          req_fire, pop, push, discard;

  assign redir_pc    = redirect_pc & 32'hFFFF_FFFC;
  assign credit_sum  = {1'b0, count} + {1'b0, outstanding};
  assign instr_valid = (count != '0);
  assign req_addr    = fetch_pc;
  assign req_fire    = req_valid & req_ready;
  assign pop         = instr_valid & instr_ready;
  // Outside FETCH every response belongs to an abandoned stream; in the redirect cycle too.
  assign discard     = redirect | (state != FETCH) | (stale != '0);
  assign push        = resp_valid & ~discard;
  assign out_next    = outstanding + CW'(req_fire) - CW'(resp_valid);
  assign instr       = instr_valid ? q_data[rd_ptr] : last_instr;
  assign instr_pc    = instr_valid ? q_pc[rd_ptr]   : last_pc;

  always_comb begin
    stale_next = stale;
    if (state == FETCH && redirect)
      stale_next = out_next;
    else if (state == DRAIN)
      stale_next = stale - CW'(resp_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH:   if (redirect && out_next != '0) state_next = DRAIN;
      DRAIN:   if (stale_next == '0) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_valid = 1'b0;
    if (state == FETCH)
      req_valid = (credit_sum < DEPTH_C) && (outstanding < MAXO_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      stale       <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      last_instr  <= '0;
      last_pc     <= '0;
    end else begin
      outstanding <= out_next;
      stale       <= stale_next;
      if (instr_valid) begin
        last_instr <= q_data[rd_ptr];
        last_pc    <= q_pc[rd_ptr];
      end
      // resp_pc tracks the address of the next non-stale response, so tags need no PC FIFO.
      if (redirect) begin
        fetch_pc <= redir_pc;
        resp_pc  <= redir_pc;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
          wr_ptr  <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= resp_data;
      q_pc[wr_ptr]   <= resp_pc;
    end
  end

`ifdef FETCH_STATS_EN
  logic [CW:0] flush_inc;
  logic [32:0] fetched_sum, flushed_sum;

  always_comb begin
    flush_inc = '0;
    if (redirect)
      flush_inc = {1'b0, count} - {{CW{1'b0}}, pop};
    flush_inc = flush_inc + {{CW{1'b0}}, resp_valid & discard};
  end

  assign fetched_sum = {1'b0, stat_fetched} + 33'(pop);
  assign flushed_sum = {1'b0, stat_flushed} + 33'(flush_inc);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetched <= '0;
      stat_flushed <= '0;
    end else begin
      stat_fetched <= fetched_sum[32] ? '1 : fetched_sum[31:0];
      stat_flushed <= flushed_sum[32] ? '1 : flushed_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: vector table plus hand-written redirect/stall/reset sequences.
// Memory model returns word = address + 0x1000_0000 after a programmable latency.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, resp_valid, instr_valid, instr_ready, redirect;
  logic [31:0] req_addr, resp_data, instr, instr_pc, redirect_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_flushed;
`endif

  instr_fetch_queue #(
    .DEPTH(4),
    .RESET_PC(32'h0000_0000),
    .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .resp_valid(resp_valid),
    .resp_data(resp_data),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc),
    .redirect(redirect),
    .redirect_pc(redirect_pc)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched(stat_fetched),
    .stat_flushed(stat_flushed)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned lat     = 1;
  logic        mv [8];
  logic [31:0] ma [8];
  logic        s_rv, s_iv, s_fire;
  logic [31:0] s_addr, s_pc, s_instr;

  typedef struct {
    logic        rst, rr, ir, rd;
    logic [31:0] rpc;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] pc, ins;
  } vec_t;
  vec_t tbl [20];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h1000_0000;
  endfunction

  function automatic vec_t mk(input logic r, rr, ir, rd, input logic [31:0] rpc,
                              input logic rv, input logic [31:0] addr, input logic iv,
                              input logic [31:0] pc, ins);
    vec_t v;
    v.rst = r; v.rr = rr; v.ir = ir; v.rd = rd; v.rpc = rpc;
    v.rv = rv; v.addr = addr; v.iv = iv; v.pc = pc; v.ins = ins;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic r, rr, ir, rd, input logic [31:0] rpc);
    rst = r; req_ready = rr; instr_ready = ir; redirect = rd; redirect_pc = rpc;
  endtask

  // One cycle: drive memory response, sample outputs, clock, advance memory pipeline.
  task automatic step();
    resp_valid = mv[0];
    resp_data  = mv[0] ? mem_word(ma[0]) : 32'h0;
    #1;
    s_rv = req_valid; s_addr = req_addr; s_iv = instr_valid; s_pc = instr_pc; s_instr = instr;
    s_fire = req_valid & req_ready;
    @(posedge clk);
    for (int i = 0; i < 7; i++) begin
      mv[i] = mv[i+1];
      ma[i] = ma[i+1];
    end
    mv[7] = 1'b0;
    if (s_fire) begin
      mv[lat-1] = 1'b1;
      ma[lat-1] = s_addr;
    end
    if (rst) for (int i = 0; i < 8; i++) mv[i] = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_table(input int unsigned last, input bit check_en);
    for (int unsigned i = 0; i <= last; i++) begin
      set_in(tbl[i].rst, tbl[i].rr, tbl[i].ir, tbl[i].rd, tbl[i].rpc);
      step();
      if (check_en)
        check($sformatf("vec%0d", i), {s_rv, s_addr, s_iv, s_pc, s_instr},
              {tbl[i].rv, tbl[i].addr, tbl[i].iv, tbl[i].pc, tbl[i].ins});
    end
  endtask

  task automatic do_reset();
    set_in(1, 1, 0, 0, 32'h0);
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned fires;
    bit found;
    for (int i = 0; i < 8; i++) begin mv[i] = 1'b0; ma[i] = 32'h0; end
    resp_valid = 1'b0; resp_data = 32'h0;
    //             rst rr ir rd rpc           rv addr          iv pc            instr
    tbl[0]  = mk(1, 1, 1, 0, 32'h0,       0, 32'h0,        0, 32'h0,       32'h0);
    tbl[1]  = mk(0, 1, 1, 0, 32'h0,       0, 32'h0,        0, 32'h0,       32'h0);
    tbl[2]  = mk(0, 1, 1, 0, 32'h0,       1, 32'h0,        0, 32'h0,       32'h0);
    tbl[3]  = mk(0, 1, 1, 0, 32'h0,       1, 32'h4,        0, 32'h0,       32'h0);
    tbl[4]  = mk(0, 1, 1, 0, 32'h0,       1, 32'h8,        1, 32'h0,       32'h1000_0000);
    tbl[5]  = mk(0, 1, 1, 0, 32'h0,       1, 32'hC,        1, 32'h4,       32'h1000_0004);
    tbl[6]  = mk(0, 1, 0, 0, 32'h0,       1, 32'h10,       1, 32'h8,       32'h1000_0008);
    tbl[7]  = mk(0, 1, 0, 0, 32'h0,       1, 32'h14,       1, 32'h8,       32'h1000_0008);
    tbl[8]  = mk(0, 1, 0, 0, 32'h0,       0, 32'h18,       1, 32'h8,       32'h1000_0008);
    tbl[9]  = mk(0, 1, 0, 0, 32'h0,       0, 32'h18,       1, 32'h8,       32'h1000_0008);
    tbl[10] = mk(0, 1, 0, 0, 32'h0,       0, 32'h18,       1, 32'h8,       32'h1000_0008);
    tbl[11] = mk(0, 1, 1, 0, 32'h0,       0, 32'h18,       1, 32'h8,       32'h1000_0008);
    tbl[12] = mk(0, 1, 1, 0, 32'h0,       1, 32'h18,       1, 32'hC,       32'h1000_000C);
    tbl[13] = mk(0, 1, 1, 0, 32'h0,       1, 32'h1C,       1, 32'h10,      32'h1000_0010);
    tbl[14] = mk(0, 1, 1, 0, 32'h0,       1, 32'h20,       1, 32'h14,      32'h1000_0014);
    tbl[15] = mk(0, 1, 1, 1, 32'h103,     1, 32'h24,       1, 32'h18,      32'h1000_0018);
    tbl[16] = mk(0, 1, 1, 0, 32'h0,       0, 32'h100,      0, 32'h18,      32'h1000_0018);
    tbl[17] = mk(0, 1, 1, 0, 32'h0,       1, 32'h100,      0, 32'h18,      32'h1000_0018);
    tbl[18] = mk(0, 1, 1, 0, 32'h0,       1, 32'h104,      0, 32'h18,      32'h1000_0018);
    tbl[19] = mk(0, 1, 1, 0, 32'h0,       1, 32'h108,      1, 32'h100,     32'h1000_0100);

    set_in(1, 1, 1, 0, 32'h0);
    @(negedge clk);
    lat = 1;
    do_reset();
    run_table(19, 1'b1);

    // Fill with core stalled: exactly four requests, then drain 0x0..0xC and resume at 0x10.
    lat = 1;
    do_reset();
    fires = 0;
    for (int i = 0; i < 10; i++) begin
      set_in(0, 1, 0, 0, 32'h0);
      step();
      if (s_fire) fires++;
    end
    check("fill_req_count", 128'(fires), 128'(4));
    check("fill_req_valid_low", 128'(s_rv), 128'(0));
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, 1, 0, 32'h0);
      step();
      check($sformatf("drain_pc%0d", i), {s_iv, s_pc, s_instr},
            {1'b1, 32'(4 * i), mem_word(32'(4 * i))});
      if (i == 1) check("resume_addr", {s_rv, s_addr}, {1'b1, 32'h10});
    end

    // Latency 3: redirect with 0x8/0xC in flight; both discarded, fetch restarts at 0x40.
    lat = 3;
    do_reset();
    set_in(0, 1, 0, 0, 32'h0);
    for (int i = 0; i < 6; i++) step();
    set_in(0, 1, 0, 1, 32'h40);
    step();
    set_in(0, 1, 0, 0, 32'h0);
    step();
    check("drain_outputs", {s_rv, s_iv}, {1'b0, 1'b0});
    step();
    check("refetch_addr", {s_rv, s_addr}, {1'b1, 32'h40});
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("no_stale_word%0d", i), 128'(s_iv), 128'(0));
    end
    step();
    check("first_after_redirect", {s_iv, s_pc, s_instr}, {1'b1, 32'h40, mem_word(32'h40)});

    // Request stall at 0x20 holds req_valid/req_addr; reset mid-stall clears the front-end.
    lat = 1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      set_in(0, 1, 1, 0, 32'h0);
      step();
      if (s_fire && s_addr == 32'h1C) found = 1'b1;
    end
    check("reach_0x1c", 128'(found), 128'(1));
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 1, 0, 32'h0);
      step();
      check($sformatf("stall_hold%0d", i), {s_rv, s_addr}, {1'b1, 32'h20});
    end
    set_in(1, 0, 1, 0, 32'h0);
    step();
    step();
    check("reset_mid_stall", {s_rv, s_addr, s_iv, s_pc, s_instr},
          {1'b0, 32'h0, 1'b0, 32'h0, 32'h0});

`ifdef FETCH_STATS_EN
    // Six handshakes, then redirect flushing two queued words and one in-cycle response.
    lat = 1;
    run_table(14, 1'b0);
    set_in(0, 0, 0, 1, 32'h200);
    step();
    check("stat_fetched", 128'(stat_fetched), 128'(6));
    check("stat_flushed", 128'(stat_flushed), 128'(3));
    check("stats_after_flush", {instr_valid, req_valid, req_addr}, {1'b0, 1'b1, 32'h200});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
